// File: rtl/dvp_capture_ctrl.sv
// DVP capture sequencer: pairs camera bytes into RGB565 pixels, marks SOF/EOL and checks frame geometry.
// Build option DVP_CAPTURE_TESTPAT_EN adds testpat_sel, which replaces pixel data with {line, pixel} indices.
module dvp_capture_ctrl #(
    parameter int H_ACTIVE  = 640,
    parameter int V_ACTIVE  = 480,
    parameter bit MSB_FIRST = 1'b1,
    parameter bit VSYNC_POL = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        cfg_ready,
    input  logic        vsync,
    input  logic        de,
    input  logic [7:0]  data,
`ifdef DVP_CAPTURE_TESTPAT_EN
    input  logic        testpat_sel,
`endif
    output logic [15:0] pix_data,
    output logic        pix_valid,
    output logic        pix_sof,
    output logic        pix_eol,
    output logic        frame_done,
    output logic        frame_err,
    output logic [15:0] frame_count,
    output logic        busy
);

    localparam int PW = $clog2(H_ACTIVE + 1);
    localparam int LW = $clog2(V_ACTIVE + 1);
    localparam logic [PW-1:0] PIX_MAX  = PW'(H_ACTIVE);
    localparam logic [PW-1:0] PIX_LAST = PW'(H_ACTIVE - 1);
    localparam logic [LW-1:0] LINE_MAX = LW'(V_ACTIVE);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARM,
        S_SYNC,
        S_ACTIVE
    } state_t;

    state_t          r_state;
    state_t          w_state_next;

    logic            r_vs_act;
    logic            r_de;
    logic            r_phase;
    logic [7:0]      r_first_byte;
    logic [PW-1:0]   r_pix_cnt;
    logic [LW-1:0]   r_line_cnt;
    logic            r_err;
    logic            r_sof_pending;

    logic            w_vs_act;
    logic            w_vs_rise;
    logic            w_vs_fall;
    logic            w_take_byte;
    logic            w_line_close;
    logic            w_frame_end;
    logic            w_pair;
    logic            w_emit;
    logic            w_drop;
    logic            w_close_bad;
    logic            w_end_bad;
    logic            w_err_next;
    logic [PW-1:0]   w_pix_inc;
    logic [LW-1:0]   w_line_inc;
    logic [LW-1:0]   w_line_at_end;
    logic [15:0]     w_cam_pix;
    logic [15:0]     w_pix_out;

    assign w_vs_act  = (vsync == VSYNC_POL);
    assign w_vs_rise = w_vs_act & ~r_vs_act;
    assign w_vs_fall = ~w_vs_act & r_vs_act;

    assign busy = (r_state != S_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // NOTE: every signal assigned here gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        w_state_next = r_state;
        w_take_byte  = 1'b0;
        w_line_close = 1'b0;
        w_frame_end  = 1'b0;
        if (!cfg_ready) begin
            w_state_next = S_IDLE;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (enable) w_state_next = S_ARM;
                end
                S_ARM: begin
                    if (w_vs_rise) w_state_next = S_SYNC;
                end
                S_SYNC: begin
                    if (w_vs_fall) w_state_next = S_ACTIVE;
                end
                S_ACTIVE: begin
                    // A line still open when blanking starts is closed as if de had fallen.
                    w_line_close = r_de & (~de | w_vs_rise);
                    if (w_vs_rise) begin
                        w_frame_end  = 1'b1;
                        w_state_next = enable ? S_SYNC : S_IDLE;
                    end else begin
                        w_take_byte = de;
                    end
                end
                default: w_state_next = S_IDLE;
            endcase
        end
    end

    assign w_pix_inc  = (r_pix_cnt == PIX_MAX) ? r_pix_cnt : r_pix_cnt + PW'(1);
    assign w_line_inc = (r_line_cnt == LINE_MAX) ? r_line_cnt : r_line_cnt + LW'(1);

    assign w_pair = w_take_byte & r_phase;
    assign w_emit = w_pair & (r_pix_cnt < PIX_MAX) & (r_line_cnt < LINE_MAX);
    assign w_drop = w_pair & ~w_emit;

    assign w_close_bad   = w_line_close & (r_phase | (r_pix_cnt != PIX_MAX));
    assign w_line_at_end = w_line_close ? w_line_inc : r_line_cnt;
    assign w_end_bad     = w_frame_end & (w_line_at_end != LINE_MAX);
    assign w_err_next    = r_err | w_close_bad | w_drop | w_end_bad;

    assign w_cam_pix = MSB_FIRST ? {r_first_byte, data} : {data, r_first_byte};

`ifdef DVP_CAPTURE_TESTPAT_EN
    logic [15:0] w_line_ext;
    logic [15:0] w_pix_ext;
    assign w_line_ext = 16'(r_line_cnt);
    assign w_pix_ext  = 16'(r_pix_cnt);
    assign w_pix_out  = testpat_sel ? {w_line_ext[7:0], w_pix_ext[7:0]} : w_cam_pix;
`else
    assign w_pix_out  = w_cam_pix;
`endif

    // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vs_act      <= 1'b0;
            r_de          <= 1'b0;
            r_phase       <= 1'b0;
            r_first_byte  <= '0;
            r_pix_cnt     <= '0;
            r_line_cnt    <= '0;
            r_err         <= 1'b0;
            r_sof_pending <= 1'b0;
            pix_data      <= '0;
            pix_valid     <= 1'b0;
            pix_sof       <= 1'b0;
            pix_eol       <= 1'b0;
            frame_done    <= 1'b0;
            frame_err     <= 1'b0;
            frame_count   <= '0;
        end else begin
            r_vs_act   <= w_vs_act;
            r_de       <= de;
            pix_valid  <= 1'b0;
            pix_sof    <= 1'b0;
            pix_eol    <= 1'b0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;

            if (r_state == S_SYNC) begin
                r_phase       <= 1'b0;
                r_pix_cnt     <= '0;
                r_line_cnt    <= '0;
                r_err         <= 1'b0;
                r_sof_pending <= 1'b1;
            end else begin
                r_err <= w_err_next;

                if (w_take_byte) begin
                    r_phase <= ~r_phase;
                    if (!r_phase) begin
                        r_first_byte <= data;
                    end else begin
                        r_pix_cnt <= w_pix_inc;
                    end
                end

                if (w_emit) begin
                    pix_valid     <= 1'b1;
                    pix_data      <= w_pix_out;
                    pix_sof       <= r_sof_pending;
                    pix_eol       <= (r_pix_cnt == PIX_LAST);
                    r_sof_pending <= 1'b0;
                end

                if (w_line_close) begin
                    r_phase    <= 1'b0;
                    r_pix_cnt  <= '0;
                    r_line_cnt <= w_line_inc;
                end

                if (w_frame_end) begin
                    frame_done  <= 1'b1;
                    frame_err   <= w_err_next;
                    frame_count <= frame_count + 16'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_dvp_capture_ctrl.sv
// Scoreboard bench for dvp_capture_ctrl: two instances (MSB-first and LSB-first) share one DVP stream.
// Expected pixels are queued as bytes are driven and popped when each instance presents pix_valid.
module tb_dvp_capture_ctrl;

    localparam int H = 4;
    localparam int V = 3;

    typedef struct packed {
        logic [15:0] dm;
        logic [15:0] dl;
        logic        sof;
        logic        eol;
    } px_t;

    logic        clk;
    logic        rst;
    logic        enable;
    logic        cfg_ready;
    logic        vsync;
    logic        de;
    logic [7:0]  data;
`ifdef DVP_CAPTURE_TESTPAT_EN
    logic        testpat_sel;
`endif

    logic [15:0] pix_data,   l_pix_data;
    logic        pix_valid,  l_pix_valid;
    logic        pix_sof,    l_pix_sof;
    logic        pix_eol,    l_pix_eol;
    logic        frame_done, l_frame_done;
    logic        frame_err,  l_frame_err;
    logic [15:0] frame_count, l_frame_count;
    logic        busy,       l_busy;

    int   n_total;
    int   n_bad;
    int   n_done;
    logic last_err;
    int   exp_nd;
    int   exp_fc;
    bit   tp_on;
    bit   sof_pend;
    int   en_off_byte;
    int   line_bytes [8];
    px_t  qm [$];
    px_t  ql [$];

    dvp_capture_ctrl #(
        .H_ACTIVE (H),
        .V_ACTIVE (V),
        .MSB_FIRST(1'b1),
        .VSYNC_POL(1'b1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .cfg_ready  (cfg_ready),
        .vsync      (vsync),
        .de         (de),
        .data       (data),
`ifdef DVP_CAPTURE_TESTPAT_EN
        .testpat_sel(testpat_sel),
`endif
        .pix_data   (pix_data),
        .pix_valid  (pix_valid),
        .pix_sof    (pix_sof),
        .pix_eol    (pix_eol),
        .frame_done (frame_done),
        .frame_err  (frame_err),
        .frame_count(frame_count),
        .busy       (busy)
    );

    dvp_capture_ctrl #(
        .H_ACTIVE (H),
        .V_ACTIVE (V),
        .MSB_FIRST(1'b0),
        .VSYNC_POL(1'b1)
    ) dut_lsb (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .cfg_ready  (cfg_ready),
        .vsync      (vsync),
        .de         (de),
        .data       (data),
`ifdef DVP_CAPTURE_TESTPAT_EN
        .testpat_sel(testpat_sel),
`endif
        .pix_data   (l_pix_data),
        .pix_valid  (l_pix_valid),
        .pix_sof    (l_pix_sof),
        .pix_eol    (l_pix_eol),
        .frame_done (l_frame_done),
        .frame_err  (l_frame_err),
        .frame_count(l_frame_count),
        .busy       (l_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin : mon_msb
        px_t e;
        if (pix_valid === 1'b1) begin
            if (qm.size() == 0) begin
                check("px_extra_msb", qm.size(), 1);
            end else begin
                e = qm.pop_front();
                check("px_data_msb", pix_data, e.dm);
                check("px_sof_msb", pix_sof, e.sof);
                check("px_eol_msb", pix_eol, e.eol);
            end
        end
        if (frame_done === 1'b1) begin
            n_done++;
            last_err = frame_err;
        end
    end

    always @(negedge clk) begin : mon_lsb
        px_t e;
        if (l_pix_valid === 1'b1) begin
            if (ql.size() == 0) begin
                check("px_extra_lsb", ql.size(), 1);
            end else begin
                e = ql.pop_front();
                check("px_data_lsb", l_pix_data, e.dl);
                check("px_sof_lsb", l_pix_sof, e.sof);
                check("px_eol_lsb", l_pix_eol, e.eol);
            end
        end
    end

    task automatic drive(input logic vs, input logic d_en, input logic [7:0] d);
        @(posedge clk);
        #1;
        vsync = vs;
        de    = d_en;
        data  = d;
    endtask

    // One line of bytes 0x10, 0x11, ... followed by `gap` idle cycles.
    task automatic send_line(input int nbytes, input int li, input bit expect_px, input int gap);
        for (int j = 0; j < nbytes; j++) begin
            int          p;
            logic [7:0]  b0;
            logic [7:0]  b1;
            px_t         e;
            drive(1'b0, 1'b1, 8'(8'h10 + j));
            if (li == 0 && j == en_off_byte) enable = 1'b0;
            if (expect_px && (j % 2 == 1)) begin
                p  = j / 2;
                b0 = 8'(8'h10 + j - 1);
                b1 = 8'(8'h10 + j);
                if (p < H && li < V) begin
                    e.dm  = {b0, b1};
                    e.dl  = {b1, b0};
                    if (tp_on) begin
                        e.dm = {8'(li), 8'(p)};
                        e.dl = {8'(li), 8'(p)};
                    end
                    e.sof = sof_pend;
                    e.eol = (p == H - 1);
                    sof_pend = 1'b0;
                    qm.push_back(e);
                    ql.push_back(e);
                end
            end
        end
        repeat (gap) drive(1'b0, 1'b0, 8'h00);
    endtask

    task automatic send_active(input int nlines, input bit expect_px, input bit hold_last);
        drive(1'b0, 1'b0, 8'h00);
        drive(1'b0, 1'b0, 8'h00);
        sof_pend = 1'b1;
        for (int l = 0; l < nlines; l++) begin
            send_line(line_bytes[l], l, expect_px, (hold_last && l == nlines - 1) ? 0 : 3);
        end
    endtask

    task automatic blank(input int n, input bit hold);
        if (hold) begin
            drive(1'b1, 1'b1, 8'hAA);
            n--;
        end
        repeat (n) drive(1'b1, 1'b0, 8'h00);
    endtask

    function automatic logic frame_bad(input int nlines);
        logic bad;
        bad = (nlines != V);
        for (int l = 0; l < nlines; l++) begin
            if (line_bytes[l] != 2 * H) bad = 1'b1;
        end
        return bad;
    endfunction

    task automatic set_lines(input int a, input int b, input int c, input int d);
        line_bytes[0] = a;
        line_bytes[1] = b;
        line_bytes[2] = c;
        line_bytes[3] = d;
    endtask

    task automatic end_frame(input logic exp_err, input bit hold);
        blank(5, hold);
        exp_nd++;
        exp_fc = (exp_fc + 1) % 65536;
        check("done_cnt", n_done, exp_nd);
        check("frame_err", last_err, exp_err);
        check("frame_count", frame_count, exp_fc);
        check("sb_empty", qm.size() + ql.size(), 0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_pix_valid"}, pix_valid, 0);
        check({tag, "_pix_data"}, pix_data, 0);
        check({tag, "_pix_sof"}, pix_sof, 0);
        check({tag, "_pix_eol"}, pix_eol, 0);
        check({tag, "_frame_done"}, frame_done, 0);
        check({tag, "_frame_err"}, frame_err, 0);
        check({tag, "_frame_count"}, frame_count, 0);
        check({tag, "_busy"}, busy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_total     = 0;
        n_bad       = 0;
        n_done      = 0;
        last_err    = 1'b0;
        exp_nd      = 0;
        exp_fc      = 0;
        tp_on       = 1'b0;
        sof_pend    = 1'b0;
        en_off_byte = -1;
        rst         = 1'b1;
        enable      = 1'b0;
        cfg_ready   = 1'b0;
        vsync       = 1'b0;
        de          = 1'b0;
        data        = 8'h00;
`ifdef DVP_CAPTURE_TESTPAT_EN
        testpat_sel = 1'b0;
`endif
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");

        // Enable while vsync is in the active-frame portion: nothing until after blanking.
        @(posedge clk);
        #1;
        rst       = 1'b0;
        enable    = 1'b1;
        cfg_ready = 1'b1;
        drive(1'b0, 1'b0, 8'h00);
        @(negedge clk);
        check("busy_armed", busy, 1);
        set_lines(8, 8, 8, 8);
        send_active(3, 1'b0, 1'b0);
        blank(5, 1'b0);
        check("arm_no_done", n_done, exp_nd);

        set_lines(8, 8, 8, 8);
        send_active(3, 1'b1, 1'b0);
        end_frame(frame_bad(3), 1'b0);

        set_lines(8, 7, 8, 8);
        send_active(3, 1'b1, 1'b0);
        end_frame(frame_bad(3), 1'b0);

        set_lines(10, 8, 8, 8);
        send_active(3, 1'b1, 1'b0);
        end_frame(frame_bad(3), 1'b0);

        set_lines(8, 8, 8, 8);
        send_active(3, 1'b1, 1'b0);
        end_frame(frame_bad(3), 1'b0);

        send_active(4, 1'b1, 1'b0);
        end_frame(frame_bad(4), 1'b0);

        send_active(2, 1'b1, 1'b0);
        end_frame(frame_bad(2), 1'b0);

        // de still high when vsync enters blanking.
        send_active(3, 1'b1, 1'b1);
        end_frame(frame_bad(3), 1'b1);

        // Disable during the first line: frame still completes, then IDLE.
        en_off_byte = 3;
        send_active(3, 1'b1, 1'b0);
        en_off_byte = -1;
        end_frame(frame_bad(3), 1'b0);
        check("busy_after_disable", busy, 0);

        // cfg_ready lost mid-line: partial frame discarded.
        enable = 1'b1;
        send_active(3, 1'b0, 1'b0);
        blank(5, 1'b0);
        check("rearm_no_done", n_done, exp_nd);
        drive(1'b0, 1'b0, 8'h00);
        drive(1'b0, 1'b0, 8'h00);
        sof_pend = 1'b1;
        send_line(8, 0, 1'b1, 3);
        send_line(4, 1, 1'b1, 0);
        drive(1'b0, 1'b1, 8'h14);
        cfg_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("busy_cfg_drop", busy, 0);
        drive(1'b0, 1'b0, 8'h00);
        cfg_ready = 1'b1;
        blank(5, 1'b0);
        check("cfg_drop_no_done", n_done, exp_nd);
        check("cfg_drop_fc", frame_count, exp_fc);
        check("cfg_drop_sb_empty", qm.size() + ql.size(), 0);

        // Synchronous reset in the middle of a line.
        drive(1'b0, 1'b0, 8'h00);
        drive(1'b0, 1'b0, 8'h00);
        sof_pend = 1'b1;
        send_line(8, 0, 1'b1, 3);
        send_line(2, 1, 1'b1, 0);
        drive(1'b0, 1'b1, 8'h12);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_all_zero("mid_rst");
        exp_fc = 0;
        check("mid_rst_sb_empty", qm.size() + ql.size(), 0);

        // Recovery frame (test pattern when that build option is present).
        @(posedge clk);
        #1;
        rst = 1'b0;
        drive(1'b0, 1'b0, 8'h00);
        blank(5, 1'b0);
`ifdef DVP_CAPTURE_TESTPAT_EN
        tp_on       = 1'b1;
        testpat_sel = 1'b1;
`endif
        set_lines(8, 8, 8, 8);
        send_active(3, 1'b1, 1'b0);
        end_frame(frame_bad(3), 1'b0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
